adc_responder: RTL and testbench
================================

ADC_RESPONDER -- requirements
Module: adc_responder

Interface
REQ-001 SHALL have parameter CONV_CYCLES, default 50, meaning clocks spent in conversion per command (legal range 1..65535).
REQ-002 SHALL have parameter TEMP_BASE, default 12'd3431, meaning first raw value of the channel-17 temperature ramp.
REQ-003 SHALL have parameter TEMP_SPAN, default 128, meaning number of distinct ramp values; TEMP_BASE+TEMP_SPAN <= 4096.
REQ-004 SHALL have parameter RAMP_DIV, default 1000, meaning channel-17 conversions per ramp step (>= 1).
REQ-005 clock_in  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 command_valid  input  1  command request.
REQ-008 command_channel  input  5  requested channel.
REQ-009 command_startofpacket / command_endofpacket  input  1 each  packet markers, echoed on the response.
REQ-010 command_ready  output  1  command accepted on any edge where command_valid and command_ready are both 1.
REQ-011 response_valid  output  1  one-cycle response strobe; no backpressure.
REQ-012 response_channel  output  5  channel of the accepted command.
REQ-013 response_data  output  12  conversion result.
REQ-014 response_startofpacket / response_endofpacket  output  1 each  echoed markers.
REQ-015 bad_channel  output  1  sticky flag: a channel above 17 was accepted.

Function
REQ-016 SHALL implement states IDLE, CONVERT and RESPOND; command_ready SHALL be 1 only in IDLE.
REQ-017 On the accept edge, the block SHALL register channel and markers, load the conversion counter with CONV_CYCLES-1, and enter CONVERT.
REQ-018 In CONVERT, the counter SHALL decrement each edge; on the edge where the counter is 0, the block SHALL enter RESPOND.
REQ-019 With the accept at edge 0, response_valid SHALL be 1 only in the cycle after edge CONV_CYCLES; IDLE SHALL follow at edge CONV_CYCLES+1.
REQ-020 Minimum command spacing SHALL be CONV_CYCLES+2 cycles.
REQ-021 command_valid outside IDLE SHALL be ignored, with no effect on any state.
REQ-022 response_channel, response_data and the response markers SHALL hold their last values while response_valid is 0.
REQ-023 Data for channels 0..16 SHALL be {7'd0, channel}.
REQ-024 Data for channel 17 SHALL be the current ramp value, sampled before that conversion updates the ramp.
REQ-025 Data for channels 18..31 SHALL be 12'h000, and bad_channel SHALL set on the accept edge.
REQ-026 Ramp: each completed channel-17 response SHALL increment ramp_cnt.
REQ-027 When ramp_cnt reaches RAMP_DIV-1, ramp_cnt SHALL clear and the ramp value SHALL increment.
REQ-028 When the ramp value equals TEMP_BASE+TEMP_SPAN-1, the next ramp step SHALL wrap it to TEMP_BASE.
REQ-029 All arithmetic SHALL be unsigned, with no intermediate overflow beyond 12 bits (ramp) or 16 bits (counter).

Reset
REQ-030 While reset_n is 0: state SHALL be IDLE, and command_ready, response_valid, all response outputs, bad_channel, the counter and ramp_cnt SHALL be 0; the ramp value SHALL be TEMP_BASE.
REQ-031 command_ready SHALL be registered and SHALL rise on the first edge after reset_n deasserts.
REQ-032 Reset mid-conversion SHALL discard the pending response; no response_valid SHALL follow it.

Structure
REQ-033 A shared package (adc_st_defs) SHALL hold CH_W=5, DATA_W=12, TEMP_CHANNEL=17 and the state encoding, for use by the top level and benches.
REQ-034 The ramp SHALL be one sub-module, adc_temp_ramp, with inputs step (channel-17 response) and reset, and output value[11:0].
REQ-035 All outputs SHALL be driven directly from flops.

Verification (CONV_CYCLES=4, RAMP_DIV=2, TEMP_SPAN=3)
REQ-036 Reset release, then channel 17 with sop=1/eop=1 accepted at edge 0 -> response_valid only in the cycle after edge 4, channel=17, data=3431, sop=1, eop=1.
REQ-037 command_valid held at 1 on channel 17 -> accepts at edges 0, 6, 12, ...; data sequence 3431, 3431, 3432, 3432, 3433, 3433, 3431 (wrap).
REQ-038 Channel 5 -> data=12'h005, bad_channel=0; then channel 20 -> data=12'h000, bad_channel=1, staying 1 across later good commands until reset.
REQ-039 Channel 3 presented during CONVERT of channel 17 -> not accepted, the response reports 17, channel 3 is accepted at the next IDLE.
REQ-040 reset_n pulsed low at edge 2 of a conversion -> no response_valid, command_ready=0 during reset and 1 after release, the next channel-17 result is 3431.

Source files
------------

// File: rtl/adc_st_defs.sv
// Shared widths, channel map, state encoding and response record for the ADC responder.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package adc_st_defs;

    localparam int CH_W   = 5;
    localparam int DATA_W = 12;
    localparam logic [CH_W-1:0] TEMP_CHANNEL = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_RESPOND = 2'd2
    } adc_state_t;

    typedef struct packed {
        logic [CH_W-1:0]   channel;
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } resp_t;

    // Low channels echo their own number, the temperature channel reads the ramp, the rest read zero.
    function automatic logic [DATA_W-1:0] chan_data(input logic [CH_W-1:0]   ch,
                                                    input logic [DATA_W-1:0] temp);
        if (ch < TEMP_CHANNEL)
            return {{(DATA_W-CH_W){1'b0}}, ch};
        else if (ch == TEMP_CHANNEL)
            return temp;
        else
            return '0;
    endfunction

endpackage

// File: rtl/adc_temp_ramp.sv
// Slow temperature ramp: advances one value every RAMP_DIV steps, wrapping within [TEMP_BASE, TEMP_BASE+TEMP_SPAN-1].
// Latency: value updates on the edge after step is sampled.
// Backpressure: none; every step pulse is counted.
module adc_temp_ramp
    import adc_st_defs::*;
#(
    parameter logic [DATA_W-1:0] TEMP_BASE = 12'd3431,
    parameter int                TEMP_SPAN = 128,
    parameter int                RAMP_DIV  = 1000
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic              step,
    output logic [DATA_W-1:0] value
);

    localparam logic [DATA_W-1:0] TEMP_LAST = TEMP_BASE + DATA_W'(TEMP_SPAN - 1);
    localparam logic [15:0]       DIV_LAST  = 16'(RAMP_DIV - 1);

    logic [15:0] ramp_cnt;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            ramp_cnt <= '0;
            value    <= TEMP_BASE;
        end else if (step) begin
            if (ramp_cnt == DIV_LAST) begin
                ramp_cnt <= '0;
                value    <= (value == TEMP_LAST) ? TEMP_BASE : value + 12'd1;
            end else begin
                ramp_cnt <= ramp_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/adc_responder.sv
// ADC command/response model: accepts one channel request, waits CONV_CYCLES, emits a one-cycle result strobe.
// Latency: response_valid in the cycle after edge CONV_CYCLES (accept = edge 0); next accept no earlier than CONV_CYCLES+2.
// Backpressure: command_ready low outside IDLE; response side has none.
module adc_responder
    import adc_st_defs::*;
#(
    parameter int                CONV_CYCLES = 50,
    parameter logic [DATA_W-1:0] TEMP_BASE   = 12'd3431,
    parameter int                TEMP_SPAN   = 128,
    parameter int                RAMP_DIV    = 1000
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic              command_valid,
    input  logic [CH_W-1:0]   command_channel,
    input  logic              command_startofpacket,
    input  logic              command_endofpacket,
    output logic              command_ready,
    output logic              response_valid,
    output logic [CH_W-1:0]   response_channel,
    output logic [DATA_W-1:0] response_data,
    output logic              response_startofpacket,
    output logic              response_endofpacket,
    output logic              bad_channel
);

    localparam logic [15:0] CONV_LOAD = 16'(CONV_CYCLES - 1);

    adc_state_t        state, next_state;
    logic [15:0]       conv_cnt;
    logic [CH_W-1:0]   cmd_channel;
    logic              cmd_sop, cmd_eop;
    logic              accept, finish;
    logic [DATA_W-1:0] temp_value;
    resp_t             resp;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (command_valid && command_ready) begin
                    accept     = 1'b1;
                    next_state = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (conv_cnt == 16'd0) begin
                    finish     = 1'b1;
                    next_state = ST_RESPOND;
                end
            end
            ST_RESPOND: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            command_ready  <= 1'b0;
            response_valid <= 1'b0;
            conv_cnt       <= '0;
            cmd_channel    <= '0;
            cmd_sop        <= 1'b0;
            cmd_eop        <= 1'b0;
            resp           <= '0;
            bad_channel    <= 1'b0;
        end else begin
            state          <= next_state;
            // Ready is the registered image of "next cycle is IDLE", so it is never a combinational output.
            command_ready  <= (next_state == ST_IDLE);
            response_valid <= finish;
            if (accept) begin
                conv_cnt    <= CONV_LOAD;
                cmd_channel <= command_channel;
                cmd_sop     <= command_startofpacket;
                cmd_eop     <= command_endofpacket;
                if (command_channel > TEMP_CHANNEL)
                    bad_channel <= 1'b1;
            end else if (state == ST_CONVERT && conv_cnt != 16'd0) begin
                conv_cnt <= conv_cnt - 16'd1;
            end
            if (finish) begin
                resp.channel <= cmd_channel;
                resp.data    <= chan_data(cmd_channel, temp_value);
                resp.sop     <= cmd_sop;
                resp.eop     <= cmd_eop;
            end
        end
    end

    // The ramp steps on the same edge that captures its current value into the response.
    adc_temp_ramp #(
        .TEMP_BASE (TEMP_BASE),
        .TEMP_SPAN (TEMP_SPAN),
        .RAMP_DIV  (RAMP_DIV)
    ) u_temp_ramp (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .step     (finish && cmd_channel == TEMP_CHANNEL),
        .value    (temp_value)
    );

    assign response_channel       = resp.channel;
    assign response_data          = resp.data;
    assign response_startofpacket = resp.sop;
    assign response_endofpacket   = resp.eop;

endmodule

// File: tb/tb_adc_responder.sv
// Directed bench for adc_responder with CONV_CYCLES=4, RAMP_DIV=2, TEMP_SPAN=3.
module tb_adc_responder;
    import adc_st_defs::*;

    localparam int CONV = 4;

    logic              clock_in = 1'b0;
    logic              reset_n;
    logic              command_valid;
    logic [CH_W-1:0]   command_channel;
    logic              command_startofpacket;
    logic              command_endofpacket;
    logic              command_ready;
    logic              response_valid;
    logic [CH_W-1:0]   response_channel;
    logic [DATA_W-1:0] response_data;
    logic              response_startofpacket;
    logic              response_endofpacket;
    logic              bad_channel;

    int checks   = 0;
    int failures = 0;

    adc_responder #(
        .CONV_CYCLES (CONV),
        .TEMP_SPAN   (3),
        .RAMP_DIV    (2)
    ) dut (
        .clock_in               (clock_in),
        .reset_n                (reset_n),
        .command_valid          (command_valid),
        .command_channel        (command_channel),
        .command_startofpacket  (command_startofpacket),
        .command_endofpacket    (command_endofpacket),
        .command_ready          (command_ready),
        .response_valid         (response_valid),
        .response_channel       (response_channel),
        .response_data          (response_data),
        .response_startofpacket (response_startofpacket),
        .response_endofpacket   (response_endofpacket),
        .bad_channel            (bad_channel)
    );

    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock_in);
        reset_n = 1'b0;
        repeat (2) @(negedge clock_in);
        reset_n = 1'b1;
    endtask

    // Wait for ready, issue one command, then watch 8 negedges for exactly one response.
    task automatic issue(input string tag, input logic [4:0] ch, input logic sop, input logic eop,
                         input logic [11:0] exp_data, input logic exp_bad);
        int waited = 0;
        int first  = 0;
        int n      = 0;
        logic [4:0]  got_ch   = '0;
        logic [11:0] got_data = '0;
        logic        got_sop  = 1'b0;
        logic        got_eop  = 1'b0;
        @(negedge clock_in);
        while (!command_ready && waited < 20) begin
            @(negedge clock_in);
            waited++;
        end
        check({tag, "_rdy"}, command_ready, 1);
        command_valid         = 1'b1;
        command_channel       = ch;
        command_startofpacket = sop;
        command_endofpacket   = eop;
        @(posedge clock_in);
        #1;
        command_valid         = 1'b0;
        command_channel       = '0;
        command_startofpacket = 1'b0;
        command_endofpacket   = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock_in);
            if (response_valid) begin
                n++;
                if (first == 0) begin
                    first    = i;
                    got_ch   = response_channel;
                    got_data = response_data;
                    got_sop  = response_startofpacket;
                    got_eop  = response_endofpacket;
                end
            end
        end
        check({tag, "_lat"}, first, CONV + 1);
        check({tag, "_nresp"}, n, 1);
        check({tag, "_ch"}, got_ch, ch);
        check({tag, "_data"}, got_data, exp_data);
        check({tag, "_sop"}, got_sop, sop);
        check({tag, "_eop"}, got_eop, eop);
        check({tag, "_bad"}, bad_channel, exp_bad);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int t1, t2;
        logic [11:0] seq_data [0:6];
        int          seq_time [0:6];
        logic [11:0] exp_seq  [0:6];

        reset_n               = 1'b0;
        command_valid         = 1'b0;
        command_channel       = '0;
        command_startofpacket = 1'b0;
        command_endofpacket   = 1'b0;

        // Reset state
        repeat (2) @(negedge clock_in);
        check("rst_ready", command_ready, 0);
        check("rst_valid", response_valid, 0);
        check("rst_data", response_data, 0);
        check("rst_ch", response_channel, 0);
        check("rst_sop", response_startofpacket, 0);
        check("rst_eop", response_endofpacket, 0);
        check("rst_bad", bad_channel, 0);
        reset_n = 1'b1;
        @(posedge clock_in);
        #1;
        check("ready_after_release", command_ready, 1);

        issue("t17a", 5'd17, 1'b1, 1'b1, 12'd3431, 1'b0);
        issue("t5", 5'd5, 1'b0, 1'b1, 12'h005, 1'b0);
        repeat (3) @(negedge clock_in);
        check("hold_data", response_data, 12'h005);
        check("hold_ch", response_channel, 5);
        check("hold_eop", response_endofpacket, 1);
        issue("t20", 5'd20, 1'b1, 1'b0, 12'h000, 1'b1);
        issue("t16", 5'd16, 1'b0, 1'b0, 12'h010, 1'b1);

        // Channel 3 held during channel 17 conversion
        @(negedge clock_in);
        command_valid   = 1'b1;
        command_channel = 5'd17;
        @(posedge clock_in);
        #1;
        command_channel = 5'd3;
        n = 0; t1 = 0; t2 = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clock_in);
            if (response_valid) begin
                n++;
                if (n == 1) begin
                    t1 = i;
                    check("busy_first_ch", response_channel, 17);
                    check("busy_first_data", response_data, 12'd3431);
                end else if (n == 2) begin
                    t2 = i;
                    check("busy_second_ch", response_channel, 3);
                    check("busy_second_data", response_data, 12'h003);
                end
            end
            if (i == 7) command_valid = 1'b0;
        end
        check("busy_nresp", n, 2);
        check("busy_t1", t1, CONV + 1);
        check("busy_t2", t2, 2 * CONV + 3);
        check("busy_bad", bad_channel, 1);

        // Reset in the middle of a conversion
        @(negedge clock_in);
        command_valid   = 1'b1;
        command_channel = 5'd17;
        @(posedge clock_in);
        #1;
        command_valid = 1'b0;
        repeat (2) @(posedge clock_in);
        #1;
        reset_n = 1'b0;
        @(negedge clock_in);
        check("midrst_ready", command_ready, 0);
        check("midrst_bad", bad_channel, 0);
        check("midrst_valid", response_valid, 0);
        @(negedge clock_in);
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock_in);
            if (response_valid) n++;
        end
        check("midrst_nresp", n, 0);
        check("midrst_ready_after", command_ready, 1);
        issue("t17b", 5'd17, 1'b0, 1'b1, 12'd3431, 1'b0);

        // Valid held on channel 17: spacing and ramp wrap
        exp_seq[0] = 12'd3431; exp_seq[1] = 12'd3431;
        exp_seq[2] = 12'd3432; exp_seq[3] = 12'd3432;
        exp_seq[4] = 12'd3433; exp_seq[5] = 12'd3433;
        exp_seq[6] = 12'd3431;
        do_reset();
        command_valid   = 1'b1;
        command_channel = 5'd17;
        n = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock_in);
            if (response_valid && n < 7) begin
                seq_data[n] = response_data;
                seq_time[n] = c;
                n++;
            end
        end
        command_valid = 1'b0;
        check("ramp_nresp", n, 7);
        for (int k = 0; k < n; k++) begin
            check($sformatf("ramp_data%0d", k), seq_data[k], exp_seq[k]);
            if (k > 0)
                check($sformatf("ramp_gap%0d", k), seq_time[k] - seq_time[k-1], CONV + 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
